// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Brief    : Shared types and helpers for the iterative multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Bits needed to count 0..w-1 bit-steps; never less than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_multiplier_twos_negate.sv
`default_nettype none
// ============================================================================
// Module   : twos_negate
// Brief    : Conditional two's-complement negation (purely combinational).
// Revision : 1.0 - initial release
// ============================================================================
module twos_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  // Negate when requested, otherwise pass the value through unchanged.
  always_comb begin
    y = neg ? (~a + 1'b1) : a;
  end

endmodule
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Brief    : Radix-2 shift-add multiplier, one product bit per cycle, with
//            per-transaction signed/unsigned mode and valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH:0]   r_acc;    // extra top bit absorbs the add carry
  logic [WIDTH-1:0]   r_mcand;  // multiplicand magnitude
  logic               r_sign;   // result must be negated in FIX

  logic               w_neg1;
  logic               w_neg2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_fixed;

  // Operands are only negated when signed mode is requested and MSB is set.
  always_comb begin
    w_neg1 = is_signed & in1[WIDTH-1];
    w_neg2 = is_signed & in2[WIDTH-1];
  end

  twos_negate #(.WIDTH(WIDTH)) u_mag_in1 (
    .a   (in1),
    .neg (w_neg1),
    .y   (w_mag1)
  );

  twos_negate #(.WIDTH(WIDTH)) u_mag_in2 (
    .a   (in2),
    .neg (w_neg2),
    .y   (w_mag2)
  );

  twos_negate #(.WIDTH(2*WIDTH)) u_sign_fix (
    .a   (r_acc[2*WIDTH-1:0]),
    .neg (r_sign),
    .y   (w_fixed)
  );

  // Upper-half partial sum; fits in WIDTH+1 bits because the top bit is clear.
  always_comb begin
    w_sum = r_acc[2*WIDTH:WIDTH] + {1'b0, r_mcand};
  end

  // Control FSM and datapath with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_sign    <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_mcand  <= w_mag1;
            r_acc    <= {(WIDTH+1)'(0), w_mag2};
            r_sign   <= is_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
            r_cnt    <= '0;
            in_ready <= 1'b0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          // Multiplier LSB sits at acc[0]; add then shift right in one step.
          if (r_acc[0]) begin
            r_acc <= {1'b0, w_sum, r_acc[WIDTH-1:1]};
          end else begin
            r_acc <= r_acc >> 1;
          end
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FIX: begin
          out       <= w_fixed;
          out_valid <= 1'b1;
          r_state   <= DONE;
        end
        DONE: begin
          // Product and valid hold until the consumer takes them.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_multiplier
// Brief    : Directed self-checking bench for seq_multiplier (WIDTH = 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic           is_signed;
  logic [W-1:0]   in1;
  logic [W-1:0]   in2;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_signed (is_signed),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count rising edges from the accept edge until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Release the product and confirm the block returns to idle.
  task automatic drain(input string tag, input logic [63:0] exp);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_valid_fall"}, 64'(out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    check({tag, "_out_kept"}, out, exp);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input logic [63:0] exp, input int hold);
    int n;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in1 = a; in2 = b; is_signed = sgn; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(n);
    check({tag, "_latency"}, 64'(n), 64'(LAT));
    check({tag, "_out"}, out, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_out"}, out, exp);
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    drain(tag, exp);
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; is_signed = 1'b0; in1 = '0; in2 = '0; out_ready = 1'b0;
    #1;
    check("rst_out", out, 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0);
    run_op("s_neg1x5", 32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 0);
    run_op("s_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0);
    run_op("u_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 0);
    run_op("s_m7x6", 32'hFFFF_FFF9, 32'h0000_0006, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, 0);
    run_op("s_max_min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, 0);
    run_op("backpress", 32'h0000_1234, 32'h0000_0100, 1'b0, 64'h0000_0000_0012_3400, 10);
    run_op("zero", 32'h0000_0000, 32'h1234_5678, 1'b0, 64'd0, 0);

    // Operands wiggle every cycle while busy; only the accepted 3*7 counts.
    @(negedge clk);
    in1 = 32'd3; in2 = 32'd7; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("ign_in_ready_busy", 64'(in_ready), 64'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      in1 = $urandom; in2 = $urandom; is_signed = 1'($urandom); in_valid = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("ign_latency", 64'(n), 64'(LAT));
    check("ign_out", out, 64'd21);
    drain("ign", 64'd21);

    // Asynchronous reset ten cycles into BUSY discards the partial product.
    @(negedge clk);
    in1 = 32'hFFFF_FFFF; in2 = 32'd3; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out", out, 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 32'd6, 32'd7, 1'b0, 64'd42, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
